// File: rtl/multih_mod_if.sv
// multih_mod_if: bit-FIFO handshake, symbol strobes and I/Q sample bus of the multi-h CPM modulator
// master: drives strobes, bits, h_sync (and pn_sel); slave: the modulator.
// Option: MULTIH_MOD_PN15_EN adds pn_sel.
interface multih_mod_if;
  logic sym_en;
  logic sym2x_en;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic h_sync;
  logic signed [17:0] i_out;
  logic signed [17:0] q_out;
  logic out_valid;
  logic h_idx;
  logic underflow;
`ifdef MULTIH_MOD_PN15_EN
  logic pn_sel;
  modport master(output sym_en, sym2x_en, bit_in, bit_valid, h_sync, pn_sel,
                 input bit_ready, i_out, q_out, out_valid, h_idx, underflow);
  modport slave(input sym_en, sym2x_en, bit_in, bit_valid, h_sync, pn_sel,
                output bit_ready, i_out, q_out, out_valid, h_idx, underflow);
`else
  modport master(output sym_en, sym2x_en, bit_in, bit_valid, h_sync,
                 input bit_ready, i_out, q_out, out_valid, h_idx, underflow);
  modport slave(input sym_en, sym2x_en, bit_in, bit_valid, h_sync,
                output bit_ready, i_out, q_out, out_valid, h_idx, underflow);
`endif
endinterface

// File: rtl/multih_mod.sv
// multih_mod: binary multi-h CPM modulator (1REC, 2 samples/symbol), bit FIFO in, 18-bit I/Q out
// Ports: i_clk clock; i_rst_n async active-low reset; bus (multih_mod_if.slave):
//   sym_en/sym2x_en strobes, bit_in/bit_valid/bit_ready FIFO write side, h_sync index restart,
//   i_out/q_out/out_valid samples (2 clk after sym2x_en), h_idx current index, underflow sticky.
// Option: MULTIH_MOD_PN15_EN adds bus.pn_sel selecting a PN15 bit source instead of the FIFO.
module multih_mod #(
  parameter int H0 = 4,
  parameter int H1 = 5,
  parameter int AMPL = 131071,
  parameter int FDEPTH = 4
) (
  input logic i_clk,
  input logic i_rst_n,
  multih_mod_if.slave bus
);
  localparam int AW = FDEPTH > 1 ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);
  logic [FDEPTH-1:0] r_fifo;
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic r_dir, r_h, r_uf, r_v, r_ov;
  logic [5:0] r_phase;
  logic signed [17:0] r_i, r_q;
  logic w_empty, w_full, w_push, w_pop, w_bit, w_uf, w_dir, w_h;
  logic [5:0] w_step;
  // quarter-wave table, round(AMPL*sin(2*pi*k/64)); interior entries assume the default AMPL
  function automatic logic [16:0] quarter(input logic [4:0] k);
    case (k)
      5'd0: quarter = 17'd0;
      5'd1: quarter = 17'd12847;
      5'd2: quarter = 17'd25571;
      5'd3: quarter = 17'd38048;
      5'd4: quarter = 17'd50159;
      5'd5: quarter = 17'd61786;
      5'd6: quarter = 17'd72819;
      5'd7: quarter = 17'd83151;
      5'd8: quarter = 17'd92681;
      5'd9: quarter = 17'd101319;
      5'd10: quarter = 17'd108982;
      5'd11: quarter = 17'd115594;
      5'd12: quarter = 17'd121094;
      5'd13: quarter = 17'd125427;
      5'd14: quarter = 17'd128553;
      5'd15: quarter = 17'd130440;
      default: quarter = 17'(AMPL);
    endcase
  endfunction
  // odd quadrants mirror the index, the lower half-circle negates
  function automatic logic signed [17:0] sin_lut(input logic [5:0] p);
    logic [4:0] k;
    logic signed [17:0] m;
    k = p[4] ? 5'd16 - {1'b0, p[3:0]} : {1'b0, p[3:0]};
    m = $signed({1'b0, quarter(k)});
    sin_lut = p[5] ? -m : m;
  endfunction
  assign w_empty = r_cnt == '0;
  assign w_full = r_cnt == CW'(FDEPTH);
`ifdef MULTIH_MOD_PN15_EN
  logic [14:0] r_pn;
  assign w_pop = bus.sym_en & ~w_empty & ~bus.pn_sel;
  assign w_uf = bus.sym_en & w_empty & ~bus.pn_sel;
  assign w_bit = bus.pn_sel ? r_pn[14] : ~w_empty & r_fifo[r_rp];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_pn <= 15'h7fff;
    else if (bus.sym_en & bus.pn_sel) r_pn <= {r_pn[13:0], r_pn[14] ^ r_pn[13]};
`else
  assign w_pop = bus.sym_en & ~w_empty;
  assign w_uf = bus.sym_en & w_empty;
  assign w_bit = ~w_empty & r_fifo[r_rp];
`endif
  // a pop in the same cycle frees the slot a full FIFO needs for the write
  assign bus.bit_ready = ~w_full | w_pop;
  assign w_push = bus.bit_valid & bus.bit_ready;
  // a sym2x_en coincident with sym_en already steps with the new symbol's dir/index
  assign w_dir = bus.sym_en ? w_bit : r_dir;
  assign w_h = bus.sym_en ? ~bus.h_sync & ~r_h : r_h;
  assign w_step = w_h ? 6'(H1) : 6'(H0);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_fifo <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_dir <= 1'b1;
      r_h <= 1'b1;
      r_uf <= 1'b0;
      r_phase <= '0;
      r_v <= 1'b0;
      r_ov <= 1'b0;
      r_i <= '0;
      r_q <= '0;
    end else begin
      if (w_push) r_fifo[r_wp] <= bus.bit_in;
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (bus.sym_en) begin
        r_dir <= w_bit;
        r_h <= w_h;
      end
      if (w_uf) r_uf <= 1'b1;
      if (bus.sym2x_en) r_phase <= w_dir ? r_phase + w_step : r_phase - w_step;
      r_v <= bus.sym2x_en;
      r_ov <= r_v;
      if (r_v) begin
        r_i <= sin_lut(r_phase + 6'd16);
        r_q <= sin_lut(r_phase);
      end
    end
  assign bus.i_out = r_i;
  assign bus.q_out = r_q;
  assign bus.out_valid = r_ov;
  assign bus.h_idx = r_h;
  assign bus.underflow = r_uf;
endmodule

// File: tb/tb_multih_mod.sv
// tb_multih_mod: directed self-checking bench for multih_mod
module tb_multih_mod;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  multih_mod_if bus();
  multih_mod dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cyc(input logic se, input logic s2, input logic bv, input logic bi, input logic hs);
    bus.sym_en = se;
    bus.sym2x_en = s2;
    bus.bit_valid = bv;
    bus.bit_in = bi;
    bus.h_sync = hs;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.sym_en = 1'b0;
    bus.sym2x_en = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b0;
    bus.h_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if (bus.bit_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", bus.bit_ready); end
    checks++;
    if (bus.h_idx !== 1'b1) begin failures++; $display("FAIL reset_hidx got %b want 1", bus.h_idx); end
    checks++;
    if (bus.i_out !== 18'sd0 || bus.q_out !== 18'sd0) begin failures++; $display("FAIL reset_iq got %0d/%0d want 0/0", bus.i_out, bus.q_out); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got %b/%b want 0/0", bus.out_valid, bus.underflow); end
    checks++;
    if (dut.r_phase !== 6'd0) begin failures++; $display("FAIL reset_phase got %0d want 0", dut.r_phase); end
  endtask
  task automatic test_all_ones;
    int ph [6];
    logic hx [6];
    int di, dq;
    ph = '{4, 8, 13, 18, 22, 26};
    hx = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset;
    repeat (3) cyc(0, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(k % 2 == 0, 1, 0, 0, 0);
      checks++;
      if (dut.r_phase !== 6'(ph[k]) || bus.h_idx !== hx[k]) begin
        failures++;
        $display("FAIL ones_phase[%0d] got %0d/h%b want %0d/h%b", k, dut.r_phase, bus.h_idx, ph[k], hx[k]);
      end
      if (k == 2) begin
        di = int'(bus.i_out) - 92681;
        dq = int'(bus.q_out) - 92681;
        checks++;
        if (bus.out_valid !== 1'b1 || di > 1 || di < -1 || dq > 1 || dq < -1) begin
          failures++;
          $display("FAIL ones_phase8_iq got %0d/%0d v%b want 92681/92681 v1", bus.i_out, bus.q_out, bus.out_valid);
        end
      end
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL ones_idle got v%b uf%b want v0 uf0", bus.out_valid, bus.underflow); end
  endtask
  task automatic test_phase16;
    do_reset;
    repeat (4) cyc(0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(k % 2 == 0, 1, 0, 0, k % 2 == 0);
    checks++;
    if (dut.r_phase !== 6'd16) begin failures++; $display("FAIL p16_phase got %0d want 16", dut.r_phase); end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (bus.i_out !== 18'sd0 || bus.q_out !== 18'sd131071 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL p16_iq got %0d/%0d v%b want 0/131071 v1", bus.i_out, bus.q_out, bus.out_valid);
    end
  endtask
  task automatic test_all_zeros;
    int ph [4];
    int di, dq;
    ph = '{60, 56, 51, 46};
    do_reset;
    repeat (2) cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(k % 2 == 0, 1, 0, 0, 0);
      checks++;
      if (dut.r_phase !== 6'(ph[k])) begin failures++; $display("FAIL zeros_phase[%0d] got %0d want %0d", k, dut.r_phase, ph[k]); end
      if (k == 2) begin
        di = int'(bus.i_out) - 92681;
        dq = int'(bus.q_out) + 92681;
        checks++;
        if (di > 1 || di < -1 || dq > 1 || dq < -1) begin
          failures++;
          $display("FAIL zeros_phase56_iq got %0d/%0d want 92681/-92681", bus.i_out, bus.q_out);
        end
      end
    end
  endtask
  task automatic test_hsync;
    int ph [8];
    logic hx [8];
    ph = '{4, 8, 3, 62, 2, 6, 2, 62};
    hx = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset;
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(k % 2 == 0, 1, 0, 0, k == 6);
      checks++;
      if (dut.r_phase !== 6'(ph[k]) || bus.h_idx !== hx[k]) begin
        failures++;
        $display("FAIL hsync_step[%0d] got %0d/h%b want %0d/h%b", k, dut.r_phase, bus.h_idx, ph[k], hx[k]);
      end
    end
  endtask
  task automatic test_fifo_full;
    do_reset;
    repeat (4) cyc(0, 0, 1, 1, 0);
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b0;
    #1;
    checks++;
    if (bus.bit_ready !== 1'b0) begin failures++; $display("FAIL full_ready got %b want 0", bus.bit_ready); end
    bus.sym_en = 1'b1;
    #1;
    checks++;
    if (bus.bit_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got %b want 1", bus.bit_ready); end
    cyc(1, 0, 1, 0, 0);
    bus.sym_en = 1'b0;
    bus.bit_valid = 1'b0;
    #1;
    checks++;
    if (dut.r_cnt !== 3'd4 || bus.bit_ready !== 1'b0) begin failures++; $display("FAIL full_count got %0d rdy%b want 4 rdy0", dut.r_cnt, bus.bit_ready); end
    checks++;
    if (dut.r_dir !== 1'b1 || bus.h_idx !== 1'b0 || dut.r_phase !== 6'd0) begin
      failures++;
      $display("FAIL full_symonly got dir%b h%b ph%0d want dir1 h0 ph0", dut.r_dir, bus.h_idx, dut.r_phase);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_nosample got v%b want v0", bus.out_valid); end
  endtask
  task automatic test_underflow;
    do_reset;
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (bus.underflow !== 1'b1 || dut.r_phase !== 6'd60 || dut.r_dir !== 1'b0) begin
      failures++;
      $display("FAIL uf_first got uf%b ph%0d dir%b want uf1 ph60 dir0", bus.underflow, dut.r_phase, dut.r_dir);
    end
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (dut.r_phase !== 6'd56) begin failures++; $display("FAIL uf_second got %0d want 56", dut.r_phase); end
    cyc(0, 0, 1, 1, 0);
    checks++;
    if (bus.underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky_refill got %b want 1", bus.underflow); end
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (dut.r_phase !== 6'd61 || bus.h_idx !== 1'b1 || bus.underflow !== 1'b1) begin
      failures++;
      $display("FAIL uf_after got ph%0d h%b uf%b want ph61 h1 uf1", dut.r_phase, bus.h_idx, bus.underflow);
    end
  endtask
  task automatic test_reset_mid;
    int di, dq;
    do_reset;
    repeat (2) cyc(0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.i_out === 18'sd0) begin failures++; $display("FAIL mid_presample got v%b i%0d want v1 i!=0", bus.out_valid, bus.i_out); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.i_out !== 18'sd0 || bus.q_out !== 18'sd0 || bus.out_valid !== 1'b0 || dut.r_phase !== 6'd0) begin
      failures++;
      $display("FAIL mid_async got %0d/%0d v%b ph%0d want 0/0 v0 ph0", bus.i_out, bus.q_out, bus.out_valid, dut.r_phase);
    end
    do_reset;
    cyc(0, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0);
    checks++;
    if (dut.r_phase !== 6'd4) begin failures++; $display("FAIL mid_first_phase got %0d want 4", dut.r_phase); end
    cyc(0, 0, 0, 0, 0);
    di = int'(bus.i_out) - 121094;
    dq = int'(bus.q_out) - 50159;
    checks++;
    if (bus.out_valid !== 1'b1 || di > 1 || di < -1 || dq > 1 || dq < -1) begin
      failures++;
      $display("FAIL mid_first_iq got %0d/%0d v%b want 121094/50159 v1", bus.i_out, bus.q_out, bus.out_valid);
    end
  endtask
  initial begin
    test_reset;
    test_all_ones;
    test_phase16;
    test_all_zeros;
    test_hsync;
    test_fifo_full;
    test_underflow;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
